// File: rtl/u_dly_pkg.sv
// rtl/u_dly_pkg.sv - shared types and constants for the coarse delay-line controller
package u_dly_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;
    localparam int T_DLY_COARSE = 60;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_LOCK   = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

endpackage

// File: rtl/u_dly_maj.sv
// rtl/u_dly_maj.sv - valid-sample counter and late accumulator with majority/all-late flags
module u_dly_maj #(
    parameter int N_AVG = 8
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_late,
    output logic o_last,
    output logic o_maj_late,
    output logic o_all_late
);

    localparam int CW = $clog2(N_AVG) + 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_late;

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clr) begin
            r_cnt  <= '0;
            r_late <= '0;
        end else if (i_en) begin
            r_cnt  <= r_cnt + 1'b1;
            r_late <= r_late + CW'(i_late);
        end
    end

    // A tie (exactly N_AVG/2 late) counts as early.
    assign o_last     = (r_cnt == CW'(N_AVG - 1));
    assign o_maj_late = (r_late > CW'(N_AVG / 2));
    assign o_all_late = (r_late == CW'(N_AVG));

endmodule

// File: rtl/u_dly_coarse_ctrl.sv
// rtl/u_dly_coarse_ctrl.sv - coarse delay lock search; DLY_COARSE_TRACK_EN enables tracking while locked
module u_dly_coarse_ctrl
    import u_dly_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int N_AVG      = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_pd_valid,
    input  logic             i_pd_late,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_busy,
    output logic             o_lock,
    output logic             o_fail
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [7:0]       r_set_cnt, w_set_cnt_nxt;
    logic             r_trk, w_trk_nxt;
    logic             w_restart;
    logic             w_clr;
    logic             w_en;
    logic             w_last;
    logic             w_maj_late;
    logic             w_all_late;

    assign w_clr = (r_state != ST_SAMPLE) && (r_state != ST_DECIDE);
    assign w_en  = (r_state == ST_SAMPLE) && i_pd_valid;

    u_dly_maj #(.N_AVG(N_AVG)) u_maj (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_clr      (w_clr),
        .i_en       (w_en),
        .i_late     (i_pd_late),
        .o_last     (w_last),
        .o_maj_late (w_maj_late),
        .o_all_late (w_all_late)
    );

    // r_trk marks SETTLE/SAMPLE/DECIDE passes that run on behalf of a held lock.
    assign o_busy    = !r_trk && ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE) ||
                                  (r_state == ST_DECIDE));
    assign o_lock    = (r_state == ST_LOCK) || r_trk;
    assign o_fail    = (r_state == ST_FAIL);
    assign o_sel     = r_sel;
    assign w_restart = i_start && !o_busy;

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_set_cnt_nxt = 8'd0;
        w_trk_nxt     = r_trk;
        if (w_restart) begin
            w_state_nxt = ST_SETTLE;
            w_sel_nxt   = '0;
            w_trk_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_set_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
                    else                          w_set_cnt_nxt = r_set_cnt + 8'd1;
                end
                ST_SAMPLE: begin
                    if (i_pd_valid && w_last) w_state_nxt = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (r_trk) begin
                        if (!w_maj_late) begin
                            if (r_sel != SEL_MAX) w_sel_nxt = r_sel + 1'b1;
                        end else if (w_all_late && (r_sel != '0)) begin
                            w_sel_nxt = r_sel - 1'b1;
                        end
                        w_state_nxt = ST_SETTLE;
                    end else if (w_maj_late) begin
                        w_state_nxt = ST_LOCK;
                    end else if (r_sel == SEL_MAX) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_sel_nxt   = r_sel + 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_LOCK: begin
`ifdef DLY_COARSE_TRACK_EN
                    w_state_nxt = ST_SETTLE;
                    w_trk_nxt   = 1'b1;
`else
                    w_state_nxt = ST_LOCK;
`endif
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_set_cnt <= 8'd0;
            r_trk     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_set_cnt <= w_set_cnt_nxt;
            r_trk     <= w_trk_nxt;
        end
    end

endmodule

// File: tb/tb_u_dly_coarse_ctrl.sv
// tb/tb_u_dly_coarse_ctrl.sv - randomized self-checking bench for u_dly_coarse_ctrl
module tb_u_dly_coarse_ctrl;
    import u_dly_pkg::*;

    localparam int SETTLE_CYC = 4;
    localparam int N_AVG      = 8;

    logic             clk = 1'b0;
    logic             i_rstn;
    logic             i_start;
    logic             i_pd_valid;
    logic             i_pd_late;
    logic [SEL_W-1:0] o_sel;
    logic             o_busy;
    logic             o_lock;
    logic             o_fail;

    int n_chk  = 0;
    int n_fail = 0;
    int vmode  = 0;
    bit allow_start = 1'b1;
    int nl_tab[8];

    always #5 clk = ~clk;

    u_dly_coarse_ctrl #(.SETTLE_CYC(SETTLE_CYC), .N_AVG(N_AVG)) dut (
        .i_clk      (clk),
        .i_rstn     (i_rstn),
        .i_start    (i_start),
        .i_pd_valid (i_pd_valid),
        .i_pd_late  (i_pd_late),
        .o_sel      (o_sel),
        .o_busy     (o_busy),
        .o_lock     (o_lock),
        .o_fail     (o_fail)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        i_pd_valid = 1'($urandom);
        i_pd_late  = 1'($urandom);
        i_start    = allow_start && ($urandom_range(0, 7) == 0);
        tick();
    endtask

    // One code evaluation: settle window, N_AVG valid samples carrying exactly nl lates, decide cycle.
    task automatic do_step(input int code, input int nl);
        bit bits[N_AVG];
        bit tmp;
        bit v;
        int j;
        int g;
        int k;
        for (int i = 0; i < N_AVG; i++) bits[i] = (i < nl);
        for (int i = N_AVG - 1; i > 0; i--) begin
            k = $urandom_range(0, i);
            tmp = bits[i]; bits[i] = bits[k]; bits[k] = tmp;
        end
        repeat (SETTLE_CYC) junk();
        j = 0;
        g = 0;
        while (j < N_AVG && g < 1000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (g % 3 == 2);
                default: v = 1'($urandom);
            endcase
            i_pd_valid = v;
            i_pd_late  = v ? bits[j] : 1'($urandom);
            i_start    = allow_start && ($urandom_range(0, 7) == 0);
            tick();
            if (v) j++;
            g++;
        end
        check("sample_budget", 32'(j), N_AVG);
        check("pre_decide_sel", o_sel, code);
        if (allow_start) check("pre_decide_busy", o_busy, 1);
        junk();
        i_start = 1'b0;
    endtask

    task automatic run_search();
        int code;
        bit done;
        i_start    = 1'b1;
        i_pd_valid = 1'b0;
        tick();
        i_start = 1'b0;
        check("start_sel", o_sel, 0);
        check("start_busy", o_busy, 1);
        check("start_lock", o_lock, 0);
        code = 0;
        done = 1'b0;
        while (!done) begin
            do_step(code, nl_tab[code]);
            if (nl_tab[code] > N_AVG / 2) begin
                check("lock_sel", o_sel, code);
                check("lock_flag", o_lock, 1);
                check("lock_busy", o_busy, 0);
                check("lock_fail", o_fail, 0);
                done = 1'b1;
            end else if (code == 7) begin
                check("fail_sel", o_sel, 7);
                check("fail_flag", o_fail, 1);
                check("fail_lock", o_lock, 0);
                check("fail_busy", o_busy, 0);
                done = 1'b1;
            end else begin
                code++;
                check("step_sel", o_sel, code);
                check("step_busy", o_busy, 1);
            end
        end
    endtask

    task automatic set_thr(input int thr);
        for (int c = 0; c < 8; c++) nl_tab[c] = (c >= thr) ? N_AVG : 0;
    endtask

    task automatic hold_check(input int code, input int lk, input int fl);
        allow_start = 1'b0;
        repeat (12) junk();
        allow_start = 1'b1;
        check("hold_sel", o_sel, code);
        check("hold_lock", o_lock, lk);
        check("hold_fail", o_fail, fl);
        check("hold_busy", o_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn = 1'b0; i_start = 1'b0; i_pd_valid = 1'b0; i_pd_late = 1'b0;
        tick();
        tick();
        check("rst_sel", o_sel, 0);
        check("rst_busy", o_busy, 0);
        check("rst_lock", o_lock, 0);
        check("rst_fail", o_fail, 0);
        i_start = 1'b1;
        tick();
        check("rst_beats_start", o_busy, 0);
        i_start = 1'b0;
        i_rstn  = 1'b1;
        tick();

        vmode = 0;
        set_thr(3);
        run_search();
`ifdef DLY_COARSE_TRACK_EN
        allow_start = 1'b0;
        junk();
        do_step(3, 0);
        check("trk_sel4", o_sel, 4);
        check("trk_lock4", o_lock, 1);
        do_step(4, 0);
        check("trk_sel5", o_sel, 5);
        check("trk_lock5", o_lock, 1);
        allow_start = 1'b1;
`else
        hold_check(3, 1, 0);
`endif

        vmode = 2;
        set_thr(8);
        run_search();
        hold_check(7, 0, 1);

        vmode = 1;
        for (int c = 0; c < 8; c++) nl_tab[c] = N_AVG / 2;
        run_search();
        nl_tab[2] = N_AVG / 2 + 1;
        run_search();
        hold_check(2, 1, 0);

        vmode = 2;
        set_thr(8);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 5; c++) do_step(c, 0);
        repeat (SETTLE_CYC) junk();
        i_start    = 1'b0;
        i_pd_valid = 1'b1;
        i_pd_late  = 1'b1;
        repeat (3) tick();
        check("mid_sample_sel", o_sel, 5);
        i_rstn = 1'b0;
        tick();
        check("midrst_sel", o_sel, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_lock", o_lock, 0);
        check("midrst_fail", o_fail, 0);
        i_rstn = 1'b1;
        i_pd_valid = 1'b0;
        tick();
        set_thr($urandom_range(0, 7));
        run_search();

        for (int it = 0; it < 6; it++) begin
            vmode = $urandom_range(0, 2);
            for (int c = 0; c < 8; c++) nl_tab[c] = $urandom_range(0, N_AVG);
            run_search();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
